seven_seg_capture: RTL and testbench
====================================

SEVEN_SEG_CAPTURE -- requirements
Module: seven_seg_capture

Interface
REQ-001 Parameter STABLE_CYCLES, default 4: consecutive identical synchronized samples of (an, seg) required before a digit is accepted; range 2..255.
REQ-002 Parameter TIMEOUT_CYCLES, default 1048576: cycles without a completed frame before stale asserts; range 16..2^24.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset; rst=0 resets immediately, release is sampled on clk.
REQ-005 seg  input  7  observed segment lines a-g, active-low, bit 0 = a.
REQ-006 an  input  4  observed anode lines, active-low, bit n = digit n (digit 0 = least-significant nibble).
REQ-007 value  output  16  last complete captured frame, digit n in bits [4n+3:4n].
REQ-008 value_valid  output  1  one-cycle pulse when value updates.
REQ-009 digit_mask  output  4  digits accepted in the current frame.
REQ-010 seg_err  output  1  sticky: an accepted dwell carried an undecodable segment pattern.
REQ-011 an_err  output  1  sticky: more than one anode was seen low in a stable sample.
REQ-012 stale  output  1  high when no frame has completed within TIMEOUT_CYCLES.

Function
REQ-013 seg and an shall pass through a 2-flop synchronizer; synchronizer reset value is all ones (display dark).
REQ-014 FSM states: IDLE (no single anode low), SETTLE (counting stability), HELD (digit accepted or rejected for this dwell, waiting for change).
REQ-015 IDLE->SETTLE when synchronized an has exactly one zero bit; stability counter loads 1.
REQ-016 In SETTLE, counter increments while (an, seg) equals the previous sample; any change reloads counter to 1 (new pair), or returns to IDLE if an is no longer one-hot-low.
REQ-017 SETTLE->HELD on the edge where counter reaches STABLE_CYCLES; the decode/accept action occurs on that same edge.
REQ-018 HELD->SETTLE on any change of (an, seg) to a one-hot-low an; HELD->IDLE on any other an; no re-acceptance during one unchanged dwell.
REQ-019 Decode table (seg, a=bit0, as 7-bit g..a): 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001 5=0010010 6=0000010 7=1111000 8=0000000 9=0010000 A=0001000 B=0000011 C=1000110 D=0100001 E=0000110 F=0001110.
REQ-020 On acceptance with a decodable pattern: nibble written to shadow register slot n, digit_mask[n] set; an already-set digit is overwritten (latest wins).
REQ-021 On acceptance with an undecodable pattern (including 1111111): seg_err set, shadow and digit_mask unchanged.
REQ-022 A stable sample with two or more anodes low sets an_err and is otherwise ignored (FSM in IDLE).
REQ-023 When digit_mask becomes 1111, on the next edge: value <= shadow, value_valid=1 for exactly one cycle, digit_mask <= 0000, seg_err and an_err cleared.
REQ-024 Acceptance occurring on the same edge as frame completion belongs to the new frame (mask clear and new bit set combine; new bit wins).
REQ-025 Timeout counter resets to 0 on each value_valid, otherwise increments, saturating at TIMEOUT_CYCLES; stale=1 while counter equals TIMEOUT_CYCLES; stale deasserts on the cycle value_valid asserts.
REQ-026 Latency: stable pair at pins at edge t -> accepted at edge t+2+STABLE_CYCLES-1; fourth-digit acceptance -> value_valid one cycle later.

Reset
REQ-027 While rst=0: value=0x0000, value_valid=0, digit_mask=0000, seg_err=0, an_err=0, stale=0, FSM=IDLE, all counters 0, shadow 0.
REQ-028 Reset mid-frame discards partial shadow and mask; first frame after release requires all four digits again.

Verification
REQ-029 Scan 0x1234, 8-cycle dwell per digit, digits 0..3 -> value=0x1234, single value_valid pulse, digit_mask returns to 0000.
REQ-030 Dwell of STABLE_CYCLES-1 cycles on digit 2 then dwell 8 on digits 0,1,3 -> no value_valid, digit_mask=1011.
REQ-031 an=1110, seg=1111111 for 8 cycles -> seg_err=1, digit_mask[0]=0; later full valid frame 0xBEEF -> value=0xBEEF, seg_err=0.
REQ-032 an=1100 stable 8 cycles -> an_err=1, digit_mask unchanged, FSM IDLE.
REQ-033 TIMEOUT_CYCLES=16, no scanning after reset -> stale=1 from cycle 16; complete frame 0xA5C3 -> stale=0 on value_valid cycle.
REQ-034 rst=0 asserted after digits 0,1 of 0x9876 accepted, released, then digits 2,3 only -> no value_valid, value=0x0000, digit_mask=1100.

Source files
------------

// File: rtl/seven_seg_capture.sv
// seven_seg_capture: recovers the 4-digit hex value shown on a multiplexed,
// active-low seven-segment display by watching its anode and segment lines.
// Each digit must dwell unchanged for STABLE_CYCLES synchronized samples before
// it is accepted. Once all four digits are captured, the frame is published on
// value with a one-cycle value_valid pulse.
`timescale 1ns/1ps
module seven_seg_capture #(
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg,
  input  logic [3:0]  an,
  output logic [15:0] value,
  output logic        value_valid,
  output logic [3:0]  digit_mask,
  output logic        seg_err,
  output logic        an_err,
  output logic        stale
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HELD   = 2'd2
  } state_t;

  state_t      state, state_next;

  logic [3:0]  an_s1, an_s2, an_q;
  logic [6:0]  seg_s1, seg_s2, seg_q;
  logic [7:0]  cnt, cnt_next;
  logic [TW-1:0] tcnt;
  logic [3:0]  shadow [4];

  logic        same;
  logic        one_hot;
  logic        multi_low;
  logic [1:0]  idx;
  logic [4:0]  dec;
  logic        accept;
  logic        an_bad;
  logic        frame_done;
  logic [3:0]  mask_next;

  // Decodes an active-low g..a pattern; bit 4 of the result flags a legal digit.
  function automatic logic [4:0] decode(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'b1000000: r = {1'b1, 4'h0};
      7'b1111001: r = {1'b1, 4'h1};
      7'b0100100: r = {1'b1, 4'h2};
      7'b0110000: r = {1'b1, 4'h3};
      7'b0011001: r = {1'b1, 4'h4};
      7'b0010010: r = {1'b1, 4'h5};
      7'b0000010: r = {1'b1, 4'h6};
      7'b1111000: r = {1'b1, 4'h7};
      7'b0000000: r = {1'b1, 4'h8};
      7'b0010000: r = {1'b1, 4'h9};
      7'b0001000: r = {1'b1, 4'hA};
      7'b0000011: r = {1'b1, 4'hB};
      7'b1000110: r = {1'b1, 4'hC};
      7'b0100001: r = {1'b1, 4'hD};
      7'b0000110: r = {1'b1, 4'hE};
      7'b0001110: r = {1'b1, 4'hF};
      default:    r = '0;
    endcase
    return r;
  endfunction

  // Two-flop synchronizer plus one-sample history for change detection; resets dark.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an_s1  <= '1;
      an_s2  <= '1;
      an_q   <= '1;
      seg_s1 <= '1;
      seg_s2 <= '1;
      seg_q  <= '1;
    end else begin
      an_s1  <= an;
      an_s2  <= an_s1;
      an_q   <= an_s2;
      seg_s1 <= seg;
      seg_s2 <= seg_s1;
      seg_q  <= seg_s2;
    end
  end

  // Classifies the current synchronized sample.
  always_comb begin
    same      = (an_s2 == an_q) && (seg_s2 == seg_q);
    one_hot   = ($countones(~an_s2) == 1);
    multi_low = ($countones(~an_s2) >= 2);
    dec       = decode(seg_s2);
    case (an_s2)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
  end

  // FSM state and stability counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic. In IDLE the counter also tracks how long a multi-anode
  // sample has persisted, so only a stable one raises an_err.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    an_bad     = 1'b0;
    case (state)
      IDLE: begin
        if (one_hot) begin
          state_next = SETTLE;
          cnt_next   = 8'd1;
        end else if (multi_low) begin
          if (!same) begin
            cnt_next = 8'd1;
          end else if (cnt < 8'(STABLE_CYCLES)) begin
            cnt_next = cnt + 8'd1;
            if (cnt == 8'(STABLE_CYCLES - 1)) an_bad = 1'b1;
          end
        end else begin
          cnt_next = '0;
        end
      end
      SETTLE: begin
        if (!same) begin
          if (one_hot) begin
            cnt_next = 8'd1;
          end else begin
            state_next = IDLE;
            cnt_next   = multi_low ? 8'd1 : 8'd0;
          end
        end else if (cnt == 8'(STABLE_CYCLES - 1)) begin
          state_next = HELD;
          cnt_next   = 8'(STABLE_CYCLES);
          accept     = 1'b1;
        end else begin
          cnt_next = cnt + 8'd1;
        end
      end
      HELD: begin
        if (!same) begin
          if (one_hot) begin
            state_next = SETTLE;
            cnt_next   = 8'd1;
          end else begin
            state_next = IDLE;
            cnt_next   = multi_low ? 8'd1 : 8'd0;
          end
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Mask update: a completing frame clears the mask, a same-edge acceptance
  // is then applied on top so it lands in the new frame.
  always_comb begin
    frame_done = (digit_mask == 4'hF);
    mask_next  = frame_done ? 4'h0 : digit_mask;
    if (accept && dec[4]) mask_next[idx] = 1'b1;
  end

  // Shadow digits, published frame and sticky error flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < 4; i++) shadow[i] <= '0;
      value       <= '0;
      value_valid <= 1'b0;
      digit_mask  <= '0;
      seg_err     <= 1'b0;
      an_err      <= 1'b0;
    end else begin
      digit_mask  <= mask_next;
      value_valid <= frame_done;
      if (frame_done) value <= {shadow[3], shadow[2], shadow[1], shadow[0]};
      if (accept && dec[4]) shadow[idx] <= dec[3:0];
      if (accept && !dec[4]) seg_err <= 1'b1;
      else if (frame_done)   seg_err <= 1'b0;
      if (an_bad)          an_err <= 1'b1;
      else if (frame_done) an_err <= 1'b0;
    end
  end

  // Staleness counter: restarts on the edge that raises value_valid, saturates at the limit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tcnt <= '0;
    end else if (frame_done) begin
      tcnt <= '0;
    end else if (tcnt != TW'(TIMEOUT_CYCLES)) begin
      tcnt <= tcnt + 1'b1;
    end
  end

  // stale is combinational on the counter so it drops in the value_valid cycle.
  always_comb stale = (tcnt == TW'(TIMEOUT_CYCLES));

endmodule

// File: tb/tb_seven_seg_capture.sv
// Directed bench for seven_seg_capture: drives a scanned display, queues the
// expected frame for each complete scan and checks every value_valid pulse.
`timescale 1ns/1ps
module tb_seven_seg_capture;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [6:0]  seg = '1;
  logic [3:0]  an  = '1;
  logic [15:0] value;
  logic        value_valid;
  logic [3:0]  digit_mask;
  logic        seg_err;
  logic        an_err;
  logic        stale;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];

  seven_seg_capture #(
    .STABLE_CYCLES(4),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .seg(seg),
    .an(an),
    .value(value),
    .value_valid(value_valid),
    .digit_mask(digit_mask),
    .seg_err(seg_err),
    .an_err(an_err),
    .stale(stale)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  // Display encoding of a hex digit (g..a, active low).
  function automatic logic [6:0] enc(input logic [3:0] d);
    logic [6:0] r;
    case (d)
      4'h0: r = 7'b1000000; 4'h1: r = 7'b1111001; 4'h2: r = 7'b0100100; 4'h3: r = 7'b0110000;
      4'h4: r = 7'b0011001; 4'h5: r = 7'b0010010; 4'h6: r = 7'b0000010; 4'h7: r = 7'b1111000;
      4'h8: r = 7'b0000000; 4'h9: r = 7'b0010000; 4'hA: r = 7'b0001000; 4'hB: r = 7'b0000011;
      4'hC: r = 7'b1000110; 4'hD: r = 7'b0100001; 4'hE: r = 7'b0000110; default: r = 7'b0001110;
    endcase
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic show(input logic [3:0] a, input logic [6:0] s, input int n);
    an  = a;
    seg = s;
    tick(n);
  endtask

  task automatic show_digit(input int pos, input logic [3:0] d, input int n);
    logic [3:0] a;
    a = 4'b0001 << pos;
    show(~a, enc(d), n);
  endtask

  task automatic scan(input logic [15:0] v, input int dwell);
    for (int i = 0; i < 4; i++) show_digit(i, v[i*4 +: 4], dwell);
    show('1, '1, 4);
  endtask

  // Scoreboard consumer: every pulse must match the oldest queued frame.
  always @(negedge clk) begin
    if (rst === 1'b1 && value_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", {31'd0, value_valid}, 32'd0);
      end else begin
        check("frame_value", {16'd0, value}, {16'd0, exp_q.pop_front()});
        check("stale_on_valid", {31'd0, stale}, 32'd0);
      end
    end
  end

  initial begin
    rst = 1'b0;
    tick(2);
    check("rst_value", {16'd0, value}, 32'h0);
    check("rst_valid", {31'd0, value_valid}, 32'd0);
    check("rst_mask", {28'd0, digit_mask}, 32'd0);
    check("rst_seg_err", {31'd0, seg_err}, 32'd0);
    check("rst_an_err", {31'd0, an_err}, 32'd0);
    check("rst_stale", {31'd0, stale}, 32'd0);

    // Timeout with no scanning.
    rst = 1'b1;
    tick(15);
    check("stale_before_limit", {31'd0, stale}, 32'd0);
    tick(1);
    check("stale_at_limit", {31'd0, stale}, 32'd1);
    tick(5);
    check("stale_saturated", {31'd0, stale}, 32'd1);

    // Frame 0xA5C3 with acceptance latency probe on digit 0.
    exp_q.push_back(16'hA5C3);
    show_digit(0, 4'h3, 5);
    check("accept_not_yet", {28'd0, digit_mask}, 32'h0);
    tick(1);
    check("accept_latency", {28'd0, digit_mask}, 32'h1);
    tick(2);
    show_digit(1, 4'hC, 8);
    show_digit(2, 4'h5, 8);
    show_digit(3, 4'hA, 8);
    show('1, '1, 4);
    check("mask_clear_a5c3", {28'd0, digit_mask}, 32'h0);
    check("stale_after_frame", {31'd0, stale}, 32'd0);

    // Plain scan.
    exp_q.push_back(16'h1234);
    scan(16'h1234, 8);
    check("value_1234", {16'd0, value}, 32'h1234);
    check("mask_clear_1234", {28'd0, digit_mask}, 32'h0);

    // Later acceptance of the same digit overwrites the earlier one.
    show_digit(0, 4'h7, 8);
    exp_q.push_back(16'h4321);
    scan(16'h4321, 8);
    check("latest_wins", {16'd0, value}, 32'h4321);

    // Short dwell on digit 2 is rejected; an exactly STABLE_CYCLES dwell completes it.
    show_digit(0, 4'h5, 8);
    show_digit(1, 4'h6, 8);
    show_digit(2, 4'h7, 3);
    show_digit(3, 4'h8, 8);
    show('1, '1, 4);
    check("short_dwell_mask", {28'd0, digit_mask}, 32'hB);
    check("short_dwell_value", {16'd0, value}, 32'h4321);
    exp_q.push_back(16'h8965);
    show_digit(2, 4'h9, 4);
    show('1, '1, 4);
    check("exact_dwell_value", {16'd0, value}, 32'h8965);

    // Undecodable pattern on digit 0.
    show(4'b1110, 7'h7F, 8);
    show('1, '1, 4);
    check("seg_err_set", {31'd0, seg_err}, 32'd1);
    check("seg_err_mask", {28'd0, digit_mask}, 32'h0);
    exp_q.push_back(16'hBEEF);
    scan(16'hBEEF, 8);
    check("value_beef", {16'd0, value}, 32'hBEEF);
    check("seg_err_cleared", {31'd0, seg_err}, 32'd0);

    // Two anodes low.
    show(4'b1100, enc(4'h1), 8);
    show('1, '1, 4);
    check("an_err_set", {31'd0, an_err}, 32'd1);
    check("an_err_mask", {28'd0, digit_mask}, 32'h0);
    exp_q.push_back(16'h0F0F);
    scan(16'h0F0F, 8);
    check("an_err_cleared", {31'd0, an_err}, 32'd0);

    // Reset mid-frame discards the partial capture.
    show_digit(0, 4'h6, 8);
    show_digit(1, 4'h7, 8);
    check("partial_mask", {28'd0, digit_mask}, 32'h3);
    rst = 1'b0;
    an  = '1;
    seg = '1;
    tick(2);
    check("midrst_mask", {28'd0, digit_mask}, 32'h0);
    check("midrst_value", {16'd0, value}, 32'h0);
    rst = 1'b1;
    tick(2);
    show_digit(2, 4'h8, 8);
    show_digit(3, 4'h9, 8);
    show('1, '1, 4);
    check("post_rst_mask", {28'd0, digit_mask}, 32'hC);
    check("post_rst_value", {16'd0, value}, 32'h0);

    check("queue_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
